// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcode/func constants, ALU codes,
// datapath select encodings, FSM state and instruction-class enums, plus decode helpers.
package mips_mc_control_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned ALUCTR_W = 3;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned CLS_W    = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [OP_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUBU  = 6'b100011;
    localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

    localparam logic [ALUCTR_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUCTR_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUCTR_W-1:0] ALU_OR  = 3'b010;
    localparam logic [ALUCTR_W-1:0] ALU_LUI = 3'b011;

    localparam logic [SEL_W-1:0] DST_RT   = 2'd0;
    localparam logic [SEL_W-1:0] DST_RD   = 2'd1;
    localparam logic [SEL_W-1:0] DST_RA   = 2'd2;
    localparam logic [SEL_W-1:0] M2R_ALU  = 2'd0;
    localparam logic [SEL_W-1:0] M2R_DM   = 2'd1;
    localparam logic [SEL_W-1:0] M2R_PC   = 2'd2;
    localparam logic [SEL_W-1:0] EXT_ZERO = 2'd0;
    localparam logic [SEL_W-1:0] EXT_SIGN = 2'd1;
    localparam logic [SEL_W-1:0] EXT_LUI  = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXE    = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_e;

    typedef enum logic [CLS_W-1:0] {
        I_ADDU, I_SUBU, I_JR, I_ORI, I_ADDI, I_LW, I_SW,
        I_BEQ, I_LUI, I_J, I_JAL, I_ILLEGAL
    } instr_e;

    typedef struct packed {
        logic                alu_src;
        logic [SEL_W-1:0]    ext_op;
        logic [ALUCTR_W-1:0] alu_ctr;
    } alu_cfg_t;

    function automatic instr_e decode_instr(input logic [OP_W-1:0] op, input logic [OP_W-1:0] fn);
        instr_e c;
        c = I_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU: c = I_ADDU;
                    FN_SUBU: c = I_SUBU;
                    FN_JR:   c = I_JR;
                    default: c = I_ILLEGAL;
                endcase
            end
            OP_ORI:  c = I_ORI;
            OP_ADDI: c = I_ADDI;
            OP_LW:   c = I_LW;
            OP_SW:   c = I_SW;
            OP_BEQ:  c = I_BEQ;
            OP_LUI:  c = I_LUI;
            OP_J:    c = I_J;
            OP_JAL:  c = I_JAL;
            default: c = I_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic is_jump(input instr_e c);
        return (c == I_J) || (c == I_JAL) || (c == I_JR);
    endfunction

    // ALU operand/extend/op selection; held through MEM/WB so the address and result stay valid.
    function automatic alu_cfg_t alu_cfg(input instr_e c);
        alu_cfg_t cfg;
        cfg = '0;
        case (c)
            I_ADDU: cfg.alu_ctr = ALU_ADD;
            I_SUBU, I_BEQ: cfg.alu_ctr = ALU_SUB;
            I_ORI: begin
                cfg.alu_src = 1'b1;
                cfg.ext_op  = EXT_ZERO;
                cfg.alu_ctr = ALU_OR;
            end
            I_LUI: begin
                cfg.alu_src = 1'b1;
                cfg.ext_op  = EXT_LUI;
                cfg.alu_ctr = ALU_LUI;
            end
            I_ADDI, I_LW, I_SW: begin
                cfg.alu_src = 1'b1;
                cfg.ext_op  = EXT_SIGN;
                cfg.alu_ctr = ALU_ADD;
            end
            default: cfg = '0;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/mips_mc_wait_timer.sv
// Memory watchdog: counts cycles a request waits without mem_ready and raises a sticky timeout.
// MAX_WAIT = 0 disables expiry.
module mips_mc_wait_timer #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_req_i,
    input  logic mem_ready_i,
    output logic expire_c_o,
    output logic timeout_o
);
    import mips_mc_control_pkg::*;

    localparam logic [WAIT_W-1:0] LAST_WAIT = (MAX_WAIT == 0) ? '0 : WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    // Expiry fires on the MAX_WAIT-th consecutive unanswered request cycle.
    always_comb begin
        expire_c_o = (MAX_WAIT != 0) && mem_req_i && !mem_ready_i && (cnt_q == LAST_WAIT);
        cnt_d      = (!mem_req_i || mem_ready_i) ? '0 : cnt_q + WAIT_W'(1);
        timeout_d  = timeout_q | expire_c_o;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXE/MEM/WB/HALT) over a shared req/ready memory port.
// Define MIPS_MC_FAST_JUMP_EN to retire j/jal/jr in DECODE instead of EXE.
module mips_mc_control #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       overflow,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_sel,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       j_ctr,
    output logic       jr_ctr,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic [1:0] ExtOp,
    output logic [2:0] ALUctr,
    output logic [2:0] state_o,
    output logic       illegal,
    output logic       timeout
);
    import mips_mc_control_pkg::*;

    state_e   state_q, state_d;
    instr_e   instr_q, instr_d, dec_c, jump_cls;
    logic     illegal_q, illegal_d;
    logic     jump_en;
    logic     mem_phase;
    logic     expire_c;
    alu_cfg_t cfg;

    assign dec_c     = decode_instr(opcode, func);
    assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);

    mips_mc_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk         (clk),
        .reset       (reset),
        .mem_req_i   (mem_phase),
        .mem_ready_i (mem_ready),
        .expire_c_o  (expire_c),
        .timeout_o   (timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            instr_q   <= I_ILLEGAL;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state and datapath controls; ready/zero/overflow terms act within the current cycle.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;
        jump_en   = 1'b0;
        jump_cls  = instr_q;
        cfg       = '0;
        mem_req   = 1'b0;
        mem_sel   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = 1'b0;
        j_ctr     = 1'b0;
        jr_ctr    = 1'b0;
        RegDst    = DST_RT;
        MemToReg  = M2R_ALU;
        RegWrite  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                instr_d = dec_c;
                if (dec_c == I_ILLEGAL) begin
                    illegal_d = 1'b1;
                    PCWrite   = 1'b1;
                    state_d   = ST_FETCH;
                end
`ifdef MIPS_MC_FAST_JUMP_EN
                else if (is_jump(dec_c)) begin
                    jump_en  = 1'b1;
                    jump_cls = dec_c;
                end
`endif
                else begin
                    state_d = ST_EXE;
                end
            end
            ST_EXE: begin
                cfg = alu_cfg(instr_q);
                if ((instr_q == I_LW) || (instr_q == I_SW)) begin
                    state_d = ST_MEM;
                end else if (instr_q == I_BEQ) begin
                    PCWrite = 1'b1;
                    PCSrc   = zero;
                    state_d = ST_FETCH;
                end else if (is_jump(instr_q)) begin
                    jump_en = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                cfg      = alu_cfg(instr_q);
                mem_req  = 1'b1;
                mem_sel  = 1'b1;
                MemWrite = (instr_q == I_SW);
                if (mem_ready) begin
                    if (instr_q == I_SW) begin
                        PCWrite = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                cfg      = alu_cfg(instr_q);
                RegWrite = !((instr_q == I_ADDI) && overflow);
                PCWrite  = 1'b1;
                RegDst   = ((instr_q == I_ADDU) || (instr_q == I_SUBU)) ? DST_RD : DST_RT;
                MemToReg = (instr_q == I_LW) ? M2R_DM : M2R_ALU;
                state_d  = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase

        if (jump_en) begin
            PCWrite = 1'b1;
            j_ctr   = (jump_cls == I_J) || (jump_cls == I_JAL);
            jr_ctr  = (jump_cls == I_JR);
            if (jump_cls == I_JAL) begin
                RegWrite = 1'b1;
                RegDst   = DST_RA;
                MemToReg = M2R_PC;
            end
            state_d = ST_FETCH;
        end

        ALUSrc = cfg.alu_src;
        ExtOp  = cfg.ext_op;
        ALUctr = cfg.alu_ctr;

        if (expire_c) begin
            state_d = ST_HALT;
        end

        // Reset silences the port immediately, aborting any in-flight memory request.
        if (reset) begin
            mem_req  = 1'b0;
            mem_sel  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            PCSrc    = 1'b0;
            j_ctr    = 1'b0;
            jr_ctr   = 1'b0;
            RegDst   = DST_RT;
            MemToReg = M2R_ALU;
            ALUSrc   = 1'b0;
            RegWrite = 1'b0;
            ExtOp    = EXT_ZERO;
            ALUctr   = ALU_ADD;
        end
    end

    assign state_o = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: per-cycle expected control vectors are queued with the
// mem_ready schedule, then popped and compared each cycle half a period after the clock edge.
module tb_mips_mc_control;

    typedef enum int { K_ADDU, K_SUBU, K_JR, K_ORI, K_ADDI, K_LW, K_SW,
                       K_BEQ, K_LUI, K_J, K_JAL, K_ILL } kind_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_sel;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       j_ctr;
        logic       jr_ctr;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] ext_op;
        logic [2:0] alu_ctr;
        logic [2:0] state;
        logic       illegal;
        logic       timeout;
    } ov_t;

`ifdef MIPS_MC_FAST_JUMP_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, func;
    logic       zero, overflow, mem_ready;
    logic       mem_req, mem_sel, MemWrite, IRWrite, PCWrite, PCSrc, j_ctr, jr_ctr;
    logic [1:0] RegDst, MemToReg, ExtOp;
    logic       ALUSrc, RegWrite;
    logic [2:0] ALUctr, state_o;
    logic       illegal, timeout;

    int  n_vec = 0;
    int  n_err = 0;
    logic exp_ill = 1'b0;
    logic exp_to  = 1'b0;

    ov_t   exp_q[$];
    logic  rdy_q[$];
    string tag_q[$];

    mips_mc_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
        .overflow(overflow), .mem_ready(mem_ready), .mem_req(mem_req), .mem_sel(mem_sel),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .j_ctr(j_ctr), .jr_ctr(jr_ctr), .RegDst(RegDst), .MemToReg(MemToReg),
        .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ExtOp(ExtOp), .ALUctr(ALUctr),
        .state_o(state_o), .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic ov_t sample();
        ov_t s;
        s.mem_req = mem_req;   s.mem_sel = mem_sel;     s.mem_write = MemWrite;
        s.ir_write = IRWrite;  s.pc_write = PCWrite;    s.pc_src = PCSrc;
        s.j_ctr = j_ctr;       s.jr_ctr = jr_ctr;       s.reg_dst = RegDst;
        s.mem_to_reg = MemToReg; s.alu_src = ALUSrc;    s.reg_write = RegWrite;
        s.ext_op = ExtOp;      s.alu_ctr = ALUctr;      s.state = state_o;
        s.illegal = illegal;   s.timeout = timeout;
        return s;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic ov_t base(input logic [2:0] st);
        ov_t e;
        e = '0;
        e.state   = st;
        e.illegal = exp_ill;
        e.timeout = exp_to;
        return e;
    endfunction

    function automatic ov_t with_alu(input kind_e k, input ov_t ein);
        ov_t e;
        e = ein;
        case (k)
            K_ADDU:         e.alu_ctr = 3'b000;
            K_SUBU, K_BEQ:  e.alu_ctr = 3'b001;
            K_ORI:          begin e.alu_src = 1'b1; e.ext_op = 2'd0; e.alu_ctr = 3'b010; end
            K_LUI:          begin e.alu_src = 1'b1; e.ext_op = 2'd2; e.alu_ctr = 3'b011; end
            K_ADDI, K_LW, K_SW: begin e.alu_src = 1'b1; e.ext_op = 2'd1; e.alu_ctr = 3'b000; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic ov_t with_jump(input kind_e k, input ov_t ein);
        ov_t e;
        e = ein;
        e.pc_write = 1'b1;
        if (k == K_JR) e.jr_ctr = 1'b1;
        else           e.j_ctr  = 1'b1;
        if (k == K_JAL) begin
            e.reg_write  = 1'b1;
            e.reg_dst    = 2'd2;
            e.mem_to_reg = 2'd2;
        end
        return e;
    endfunction

    function automatic ov_t mem_vec(input kind_e k, input logic rdy);
        ov_t e;
        e = with_alu(k, base(3'd3));
        e.mem_req   = 1'b1;
        e.mem_sel   = 1'b1;
        e.mem_write = (k == K_SW);
        e.pc_write  = (k == K_SW) && rdy;
        return e;
    endfunction

    task automatic push(input string tag, input ov_t e, input logic rdy);
        exp_q.push_back(e);
        rdy_q.push_back(rdy);
        tag_q.push_back(tag);
    endtask

    // Entered and left on a falling edge; one queued vector per clock.
    task automatic drain();
        ov_t e;
        while (exp_q.size() != 0) begin
            mem_ready = rdy_q.pop_front();
            #1;
            e = exp_q.pop_front();
            check_eq(tag_q.pop_front(), 32'(sample()), 32'(e));
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input string nm, input kind_e k, input logic [5:0] op,
                             input logic [5:0] fn, input int fwait, input int mwait,
                             input logic z, input logic ovf, input bit abort_mem);
        ov_t e;
        bit  jmp;
        bit  done;
        jmp  = (k == K_J) || (k == K_JAL) || (k == K_JR);
        done = 1'b0;
        opcode = op; func = fn; zero = z; overflow = ovf;

        for (int i = 0; i < fwait; i++) begin
            e = base(3'd0); e.mem_req = 1'b1;
            push({nm, ".Fwait"}, e, 1'b0);
        end
        e = base(3'd0); e.mem_req = 1'b1; e.ir_write = 1'b1;
        push({nm, ".F"}, e, 1'b1);

        e = base(3'd1);
        if (k == K_ILL) begin
            e.pc_write = 1'b1;
            push({nm, ".D"}, e, 1'b0);
            exp_ill = 1'b1;
            done = 1'b1;
        end else if (FAST && jmp) begin
            push({nm, ".D"}, with_jump(k, e), 1'b0);
            done = 1'b1;
        end else begin
            push({nm, ".D"}, e, 1'b0);
        end

        if (!done) begin
            e = with_alu(k, base(3'd2));
            if (k == K_BEQ) begin
                e.pc_write = 1'b1; e.pc_src = z;
                done = 1'b1;
            end else if (jmp) begin
                e = with_jump(k, base(3'd2));
                done = 1'b1;
            end
            push({nm, ".E"}, e, 1'b0);
        end

        if (!done && (k == K_LW || k == K_SW)) begin
            for (int i = 0; i < mwait; i++) push({nm, ".Mwait"}, mem_vec(k, 1'b0), 1'b0);
            if (abort_mem) done = 1'b1;
            else begin
                push({nm, ".M"}, mem_vec(k, 1'b1), 1'b1);
                if (k == K_SW) done = 1'b1;
            end
        end

        if (!done) begin
            e = with_alu(k, base(3'd4));
            e.reg_write  = !((k == K_ADDI) && ovf);
            e.pc_write   = 1'b1;
            e.reg_dst    = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
            e.mem_to_reg = (k == K_LW) ? 2'd1 : 2'd0;
            push({nm, ".W"}, e, 1'b0);
        end
        drain();
    endtask

    task automatic pulse_reset(input string nm);
        reset = 1'b1;
        #1;
        check_eq({nm, ".rst"}, 32'(sample()), 32'(0));
        @(negedge clk);
        check_eq({nm, ".rst_hold"}, 32'(sample()), 32'(0));
        reset   = 1'b0;
        exp_ill = 1'b0;
        exp_to  = 1'b0;
    endtask

    initial begin
        ov_t e;
        reset = 1'b1; opcode = '0; func = '0; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        mem_ready = 1'b1; #1;
        check_eq("reset.ready1", 32'(sample()), 32'(0));
        @(negedge clk);
        mem_ready = 1'b0; #1;
        check_eq("reset.ready0", 32'(sample()), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        run_instr("addu", K_ADDU, 6'b000000, 6'b100001, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("lw3",  K_LW,   6'b100011, 6'b000000, 0, 3, 1'b0, 1'b0, 1'b0);
        run_instr("beqT", K_BEQ,  6'b000100, 6'b000000, 0, 0, 1'b1, 1'b0, 1'b0);
        run_instr("beqN", K_BEQ,  6'b000100, 6'b000000, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("addiV",K_ADDI, 6'b001000, 6'b000000, 0, 0, 1'b0, 1'b1, 1'b0);
        run_instr("ori",  K_ORI,  6'b001101, 6'b000000, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("addi", K_ADDI, 6'b001000, 6'b000000, 1, 0, 1'b0, 1'b0, 1'b0);
        run_instr("subu", K_SUBU, 6'b000000, 6'b100011, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("lui",  K_LUI,  6'b001111, 6'b000000, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("sw",   K_SW,   6'b101011, 6'b000000, 2, 1, 1'b0, 1'b0, 1'b0);
        run_instr("lw14", K_LW,   6'b100011, 6'b000000, 14, 14, 1'b0, 1'b0, 1'b0);
        run_instr("j",    K_J,    6'b000010, 6'b000000, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("jal",  K_JAL,  6'b000011, 6'b000000, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("jr",   K_JR,   6'b000000, 6'b001000, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("illop",K_ILL,  6'b111111, 6'b000000, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("addu2",K_ADDU, 6'b000000, 6'b100001, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("illfn",K_ILL,  6'b000000, 6'b000000, 0, 0, 1'b0, 1'b0, 1'b0);

        // Abort a load mid-MEM with an asynchronous reset.
        run_instr("lwab", K_LW,   6'b100011, 6'b000000, 0, 2, 1'b0, 1'b0, 1'b1);
        mem_ready = 1'b0; #1;
        check_eq("abort.pre", 32'(sample()), 32'(mem_vec(K_LW, 1'b0)));
        #2;
        pulse_reset("abort");
        run_instr("addu3",K_ADDU, 6'b000000, 6'b100001, 0, 0, 1'b0, 1'b0, 1'b0);

        // Watchdog: fetch never answered.
        for (int i = 0; i < 15; i++) begin
            e = base(3'd0); e.mem_req = 1'b1;
            push("to.F", e, 1'b0);
        end
        drain();
        exp_to = 1'b1;
        for (int i = 0; i < 4; i++) push("to.H", base(3'd7), 1'b1);
        drain();
        pulse_reset("to");
        run_instr("addu4",K_ADDU, 6'b000000, 6'b100001, 0, 0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
